flash_sample_streamer: RTL and testbench
========================================

FLASH_SAMPLE_STREAMER -- requirements
Module: flash_sample_streamer

Interface
REQ-001 Parameter NUM_WORDS, default 128: number of 32-bit flash words fetched per run (1..128).
REQ-002 Parameter BASE_ADDR, default 23'd0: flash word address of the first fetch.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-006 busy  out  1  high from the cycle after start is accepted until done.
REQ-007 done  out  1  one-cycle pulse after the last sample handshake.
REQ-008 flash_mem_read  out  1  Avalon-MM read request.
REQ-009 flash_mem_address  out  23  word address of the current read.
REQ-010 flash_mem_burstcount  out  7  constant 7'd1.
REQ-011 flash_mem_write  out  1  constant 0; flash_mem_writedata out 32, constant 0; flash_mem_byteenable out 4, constant 4'hF.
REQ-012 flash_mem_waitrequest  in  1  slave stall; read is held while high.
REQ-013 flash_mem_readdata  in  32  read word, valid when readdatavalid is high.
REQ-014 flash_mem_readdatavalid  in  1  one-cycle response strobe.
REQ-015 sample_valid  out  1  a 16-bit sample is presented.
REQ-016 sample_data  out  16  sample value.
REQ-017 sample_idx  out  8  sample index within run, 0..2*NUM_WORDS-1.
REQ-018 sample_ready  in  1  downstream accepts the sample when high with sample_valid.

Function
REQ-019 States SHALL be IDLE, REQ, WAIT, EMIT_LO, EMIT_HI, FIN.
REQ-020 IDLE: start=1 -> REQ with word counter=0; start is ignored in all other states.
REQ-021 REQ: flash_mem_read=1, flash_mem_address=BASE_ADDR+word counter; on a cycle with waitrequest=0 -> WAIT, read deasserted next cycle.
REQ-022 Address and read SHALL remain stable while waitrequest=1; no timeout.
REQ-023 WAIT: on readdatavalid=1 the word SHALL be captured in a 32-bit register -> EMIT_LO; readdatavalid arriving in the same cycle the read is accepted SHALL also be captured.
REQ-024 EMIT_LO: sample_valid=1, sample_data=word[15:0], sample_idx=2*counter; on sample_ready -> EMIT_HI.
REQ-025 EMIT_HI: sample_valid=1, sample_data=word[31:16], sample_idx=2*counter+1; on sample_ready: counter=NUM_WORDS-1 -> FIN, else counter+1 -> REQ.
REQ-026 sample_data and sample_idx SHALL hold stable while sample_valid=1 and sample_ready=0.
REQ-027 FIN: done=1 for one cycle -> IDLE; busy low in IDLE.
REQ-028 Address arithmetic SHALL be 23-bit unsigned and wrap modulo 2^23 (BASE_ADDR=23'h7FFFFF, second word at 23'h000000).
REQ-029 At most one read outstanding; readdatavalid outside WAIT SHALL be ignored.
REQ-030 Latency, zero-stall slave with readdatavalid one cycle after acceptance: start at cycle 0, read high at cycle 1, first sample_valid at cycle 3.

Reset
REQ-031 reset=1 SHALL force IDLE in the next cycle from any state, including mid-read or mid-handshake, discarding the captured word.
REQ-032 Reset values: flash_mem_read=0, flash_mem_address=0, busy=0, done=0, sample_valid=0, sample_data=0, sample_idx=0, counter=0.
REQ-033 A readdatavalid arriving after reset from a pre-reset read SHALL be ignored.

Structure
REQ-034 Package flash_stream_pkg SHALL hold the state enum, FLASH_ADDR_W=23, FLASH_DATA_W=32, SAMPLE_W=16, BURST_ONE=7'd1.
REQ-035 One sub-module, avalon_read_port, SHALL own the read/address/waitrequest/readdatavalid handshake and word capture; sample splitting and counting stay in the top.

Verification
REQ-036 Flash model returning addr*10002, BASE_ADDR=256, NUM_WORDS=1, ready tied 1 -> samples (idx0, 0x1200), (idx1, 0x0027), then done pulse.
REQ-037 Model with waitrequest high 3 cycles -> read and address 256 held 4 cycles, exactly one accepted read, same samples.
REQ-038 NUM_WORDS=128, BASE_ADDR=0, random sample_ready -> 256 samples, idx 0..255 in order, no drops/duplicates, data stable during stalls, one done.
REQ-039 reset asserted in WAIT, then readdatavalid -> no sample_valid, outputs at reset values, next start fetches BASE_ADDR again.
REQ-040 start pulsed while busy -> ignored, run completes with one done; BASE_ADDR=23'h7FFFFF, NUM_WORDS=2 -> addresses 23'h7FFFFF then 23'h000000.

Source files
------------

// File: rtl/flash_stream_pkg.sv
// Shared types and constants for the flash sample streamer.
package flash_stream_pkg;

  localparam int FLASH_ADDR_W = 23;
  localparam int FLASH_DATA_W = 32;
  localparam int SAMPLE_W     = 16;
  localparam int BURST_W      = 7;
  localparam int COUNT_W      = 7;   // word counter, 0..127
  localparam int IDX_W        = 8;   // sample index, 0..255

  localparam logic [BURST_W-1:0] BURST_ONE = 7'd1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_EMIT_LO = 3'd3,
    ST_EMIT_HI = 3'd4,
    ST_FIN     = 3'd5
  } stream_state_t;

  // Word address of fetch number 'count'; 23-bit add wraps modulo 2^23.
  function automatic logic [FLASH_ADDR_W-1:0] word_address(
    input logic [FLASH_ADDR_W-1:0] base,
    input logic [COUNT_W-1:0]      count
  );
    return base + FLASH_ADDR_W'(count);
  endfunction

endpackage

// File: rtl/avalon_read_port.sv
// Single-word Avalon-MM read master: issues one read, holds it through
// waitrequest, and captures the returned word. At most one read is in flight.
module avalon_read_port
  import flash_stream_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  // One-cycle command from the sequencer: start a read at launch_address.
  input  logic                    launch,
  input  logic [FLASH_ADDR_W-1:0] launch_address,
  // Avalon-MM read side.
  output logic                    mem_read,
  output logic [FLASH_ADDR_W-1:0] mem_address,
  input  logic                    mem_waitrequest,
  input  logic [FLASH_DATA_W-1:0] mem_readdata,
  input  logic                    mem_readdatavalid,
  // Status back to the sequencer.
  output logic                    accepted,
  output logic                    captured,
  output logic [FLASH_DATA_W-1:0] word
);

  // Set after the slave accepted the read and before the data came back.
  logic awaiting;

  // The read is taken on any cycle it is presented without waitrequest.
  assign accepted = mem_read && !mem_waitrequest;

  // Data is only taken for our own outstanding read; the same-cycle case
  // (data strobed while the read is being accepted) counts as ours too.
  // Anything else, including a late response to a read issued before a
  // reset, is dropped.
  assign captured = mem_readdatavalid && (awaiting || accepted);

  // Read request, address hold, outstanding flag and word capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read    <= 1'b0;
      mem_address <= '0;
      awaiting    <= 1'b0;
      word        <= '0;
    end else begin
      if (launch) begin
        mem_read    <= 1'b1;
        mem_address <= launch_address;
      end else if (accepted) begin
        mem_read    <= 1'b0;
      end

      if (accepted && !mem_readdatavalid) begin
        awaiting <= 1'b1;
      end else if (captured) begin
        awaiting <= 1'b0;
      end

      if (captured) begin
        word <= mem_readdata;
      end
    end
  end

endmodule

// File: rtl/flash_sample_streamer.sv
// Fetches NUM_WORDS 32-bit words from flash, one read at a time, and streams
// each word as two 16-bit samples (low half first) with a running index.
//
// Sample stream handshake: a sample transfers on a rising clock edge where
// sample_valid and sample_ready are both high. Once sample_valid rises it
// stays high, with sample_data and sample_idx unchanged, until that transfer
// happens; sample_ready may toggle freely and never depends on sample_valid.
module flash_sample_streamer
  import flash_stream_pkg::*;
#(
  parameter int                      NUM_WORDS = 128,
  parameter logic [FLASH_ADDR_W-1:0] BASE_ADDR = 23'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    flash_mem_read,
  output logic [FLASH_ADDR_W-1:0] flash_mem_address,
  output logic [BURST_W-1:0]      flash_mem_burstcount,
  output logic                    flash_mem_write,
  output logic [FLASH_DATA_W-1:0] flash_mem_writedata,
  output logic [3:0]              flash_mem_byteenable,
  input  logic                    flash_mem_waitrequest,
  input  logic [FLASH_DATA_W-1:0] flash_mem_readdata,
  input  logic                    flash_mem_readdatavalid,
  output logic                    sample_valid,
  output logic [SAMPLE_W-1:0]     sample_data,
  output logic [IDX_W-1:0]        sample_idx,
  input  logic                    sample_ready,
  output logic [2:0]              state_dbg
);

  localparam logic [COUNT_W-1:0] LAST_WORD = COUNT_W'(NUM_WORDS - 1);

  stream_state_t             state;
  logic [COUNT_W-1:0]        counter;
  logic                      launch;
  logic [FLASH_ADDR_W-1:0]   launch_address;
  logic                      accepted;
  logic                      captured;
  logic [FLASH_DATA_W-1:0]   word;

  // Write side of the flash port is never used.
  assign flash_mem_burstcount = BURST_ONE;
  assign flash_mem_write      = 1'b0;
  assign flash_mem_writedata  = '0;
  assign flash_mem_byteenable = 4'hF;

  assign state_dbg = state;

  // The captured word only changes in REQ/WAIT, so selecting its half by
  // state keeps sample_data stable for the whole emit phase.
  assign sample_data = (state == ST_EMIT_HI) ? word[31:16] : word[15:0];

  // Decide when the next read is issued and where: word 0 on start, the
  // following word when the high half of the current word is handed off.
  always_comb begin
    launch         = 1'b0;
    launch_address = word_address(BASE_ADDR, '0);
    if (state == ST_IDLE && start) begin
      launch = 1'b1;
    end else if (state == ST_EMIT_HI && sample_ready && counter != LAST_WORD) begin
      launch         = 1'b1;
      launch_address = word_address(BASE_ADDR, counter + COUNT_W'(1));
    end
  end

  avalon_read_port u_read_port (
    .clk               (clk),
    .reset             (reset),
    .launch            (launch),
    .launch_address    (launch_address),
    .mem_read          (flash_mem_read),
    .mem_address       (flash_mem_address),
    .mem_waitrequest   (flash_mem_waitrequest),
    .mem_readdata      (flash_mem_readdata),
    .mem_readdatavalid (flash_mem_readdatavalid),
    .accepted          (accepted),
    .captured          (captured),
    .word              (word)
  );

  // Run sequencer: word counting, sample presentation and run status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      counter      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
      sample_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= ST_REQ;
            counter <= '0;
            busy    <= 1'b1;
          end
        end

        ST_REQ: begin
          if (captured) begin
            state        <= ST_EMIT_LO;
            sample_valid <= 1'b1;
            sample_idx   <= {counter, 1'b0};
          end else if (accepted) begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (captured) begin
            state        <= ST_EMIT_LO;
            sample_valid <= 1'b1;
            sample_idx   <= {counter, 1'b0};
          end
        end

        ST_EMIT_LO: begin
          if (sample_ready) begin
            state      <= ST_EMIT_HI;
            sample_idx <= {counter, 1'b1};
          end
        end

        ST_EMIT_HI: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            if (counter == LAST_WORD) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              state   <= ST_REQ;
              counter <= counter + COUNT_W'(1);
            end
          end
        end

        ST_FIN: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Bench for flash_sample_streamer: three instances with different word counts
// and base addresses, each driven by a small Avalon flash model whose word at
// address a is a*10002. Expected samples come from the address arithmetic.
module tb_flash_sample_streamer;
  import flash_stream_pkg::*;

  // ---------------- clock / reset / controls ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [3];
  logic st  [3];
  int   rdy_mode [3];   // 0 low, 1 high, 2 random
  int   stall_set [3];  // waitrequest cycles per read
  int   stall_rnd [3];  // 1: random 0..3 waitrequest cycles per read
  int   lat_set [3];    // readdatavalid delay after acceptance (>=1)

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard entries: {instance, sample index, sample data}
  logic [25:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- instances, flash models, monitors ----------------
  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int NW = (g == 0) ? 1 : (g == 1) ? 128 : 2;
    localparam logic [22:0] BA = (g == 0) ? 23'd256 : (g == 1) ? 23'd0 : 23'h7FFFFF;

    logic        busy, done, read, waitreq, rdv, write, valid, ready;
    logic [22:0] address;
    logic [6:0]  burst;
    logic [31:0] wdata, rdata;
    logic [3:0]  be;
    logic [15:0] sdata;
    logic [7:0]  sidx;
    logic [2:0]  sdbg;

    int stall_cnt = 0;
    int rnd_stall = 0;
    int pend_cnt = 0;
    logic [31:0] pend_data = '0;
    int acc_total = 0;
    int rd_hi_total = 0;
    int done_total = 0;
    int hs_total = 0;
    logic [22:0] acc_log [0:511];
    int stall_now;

    logic p_valid = 1'b0, p_ready = 1'b0, p_stall = 1'b0, const_checked = 1'b0;
    logic [15:0] p_data = '0;
    logic [7:0]  p_idx = '0;
    logic [22:0] p_addr = '0;
    logic [25:0] e;

    flash_sample_streamer #(.NUM_WORDS(NW), .BASE_ADDR(BA)) dut (
      .clk                     (clk),
      .reset                   (rst[g]),
      .start                   (st[g]),
      .busy                    (busy),
      .done                    (done),
      .flash_mem_read          (read),
      .flash_mem_address       (address),
      .flash_mem_burstcount    (burst),
      .flash_mem_write         (write),
      .flash_mem_writedata     (wdata),
      .flash_mem_byteenable    (be),
      .flash_mem_waitrequest   (waitreq),
      .flash_mem_readdata      (rdata),
      .flash_mem_readdatavalid (rdv),
      .sample_valid            (valid),
      .sample_data             (sdata),
      .sample_idx              (sidx),
      .sample_ready            (ready),
      .state_dbg               (sdbg)
    );

    // Flash slave model: stalls a read, then returns a*10002 after a delay.
    assign stall_now = (stall_rnd[g] != 0) ? rnd_stall : stall_set[g];
    assign waitreq   = read && (stall_cnt < stall_now);
    assign rdv       = (pend_cnt == 1);
    assign rdata     = rdv ? pend_data : 32'hA5A5_5A5A;

    always @(posedge clk) begin
      if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
      if (read) begin
        rd_hi_total <= rd_hi_total + 1;
        if (waitreq) begin
          stall_cnt <= stall_cnt + 1;
        end else begin
          stall_cnt <= 0;
          rnd_stall <= int'($urandom_range(0, 3));
          acc_log[acc_total] <= address;
          acc_total <= acc_total + 1;
          pend_cnt  <= lat_set[g];
          pend_data <= 32'(address) * 32'd10002;
        end
      end
    end

    // Downstream ready driver.
    always @(posedge clk) begin
      #1;
      case (rdy_mode[g])
        0: ready = 1'b0;
        1: ready = 1'b1;
        default: ready = 1'($urandom_range(0, 1));
      endcase
    end

    // Monitor: reset values, hold rules, one outstanding read, scoreboard.
    always @(negedge clk) begin
      if (rst[g]) begin
        p_valid = 1'b0;
        p_stall = 1'b0;
      end else begin
        if (!const_checked) begin
          const_checked = 1'b1;
          check($sformatf("i%0d_rst_read", g), 32'(read), 0);
          check($sformatf("i%0d_rst_addr", g), 32'(address), 0);
          check($sformatf("i%0d_rst_busy", g), 32'(busy), 0);
          check($sformatf("i%0d_rst_done", g), 32'(done), 0);
          check($sformatf("i%0d_rst_valid", g), 32'(valid), 0);
          check($sformatf("i%0d_rst_data", g), 32'(sdata), 0);
          check($sformatf("i%0d_rst_idx", g), 32'(sidx), 0);
          check($sformatf("i%0d_rst_state", g), 32'(sdbg), 32'(ST_IDLE));
          check($sformatf("i%0d_burstcount", g), 32'(burst), 1);
          check($sformatf("i%0d_write", g), 32'(write), 0);
          check($sformatf("i%0d_writedata", g), wdata, 0);
          check($sformatf("i%0d_byteenable", g), 32'(be), 32'hF);
        end
        if (p_valid && !p_ready) begin
          check($sformatf("i%0d_hold_valid", g), 32'(valid), 1);
          check($sformatf("i%0d_hold_data", g), 32'(sdata), 32'(p_data));
          check($sformatf("i%0d_hold_idx", g), 32'(sidx), 32'(p_idx));
        end
        if (p_stall) begin
          check($sformatf("i%0d_read_held", g), 32'(read), 1);
          check($sformatf("i%0d_addr_held", g), 32'(address), 32'(p_addr));
        end
        if (read && !waitreq) begin
          check($sformatf("i%0d_one_outstanding", g), 32'(pend_cnt == 0), 1);
        end
        if (valid && ready) begin
          hs_total++;
          check($sformatf("i%0d_sample_expected", g), 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("i%0d_sample_inst", g), 32'(e[25:24]), g);
            check($sformatf("i%0d_sample_idx", g), 32'(sidx), 32'(e[23:16]));
            check($sformatf("i%0d_sample_data", g), 32'(sdata), 32'(e[15:0]));
          end
        end
        if (done) done_total++;
        p_valid = valid;
        p_ready = ready;
        p_data  = sdata;
        p_idx   = sidx;
        p_stall = read && waitreq;
        p_addr  = address;
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic int done_cnt(input int g);
    case (g)
      0: return gi[0].done_total;
      1: return gi[1].done_total;
      default: return gi[2].done_total;
    endcase
  endfunction

  function automatic int acc_cnt(input int g);
    case (g)
      0: return gi[0].acc_total;
      1: return gi[1].acc_total;
      default: return gi[2].acc_total;
    endcase
  endfunction

  function automatic int hs_cnt(input int g);
    case (g)
      0: return gi[0].hs_total;
      1: return gi[1].hs_total;
      default: return gi[2].hs_total;
    endcase
  endfunction

  // Expected samples of a whole run, from the address rule alone.
  task automatic push_run(input int g, input logic [22:0] base, input int nw);
    logic [22:0] a;
    logic [31:0] w;
    for (int i = 0; i < nw; i++) begin
      a = base + 23'(i);
      w = 32'(a) * 32'd10002;
      exp_q.push_back({2'(g), 8'(2 * i), w[15:0]});
      exp_q.push_back({2'(g), 8'(2 * i + 1), w[31:16]});
    end
  endtask

  // Returns one cycle after start was sampled (run cycle 1).
  task automatic pulse_start(input int g);
    @(posedge clk); #1 st[g] = 1'b1;
    @(posedge clk); #1 st[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int snap, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt(g) == snap && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_in_budget"}, 32'(done_cnt(g) > snap), 1);
    repeat (4) @(negedge clk);
    check({tag, "_one_done"}, 32'(done_cnt(g) - snap), 1);
  endtask

  // ---------------- directed sequence ----------------
  int s_done, s_acc, s_hs, s_rd;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      st[i] = 1'b0;
      rdy_mode[i] = 1;
      stall_set[i] = 0;
      stall_rnd[i] = 0;
      lat_set[i] = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clk);

    // Latency and data with a zero-stall slave, base 256, one word.
    s_done = done_cnt(0); s_acc = acc_cnt(0);
    push_run(0, 23'd256, 1);
    pulse_start(0);
    @(negedge clk);
    check("lat_c1_read", 32'(gi[0].read), 1);
    check("lat_c1_addr", 32'(gi[0].address), 256);
    check("lat_c1_busy", 32'(gi[0].busy), 1);
    check("lat_c1_valid", 32'(gi[0].valid), 0);
    @(negedge clk);
    check("lat_c2_read", 32'(gi[0].read), 0);
    check("lat_c2_valid", 32'(gi[0].valid), 0);
    @(negedge clk);
    check("lat_c3_valid", 32'(gi[0].valid), 1);
    check("lat_c3_idx", 32'(gi[0].sidx), 0);
    check("lat_c3_data", 32'(gi[0].sdata), 32'h1200);
    @(negedge clk);
    check("lat_c4_idx", 32'(gi[0].sidx), 1);
    check("lat_c4_data", 32'(gi[0].sdata), 32'h0027);
    @(negedge clk);
    check("lat_c5_done", 32'(gi[0].done), 1);
    @(negedge clk);
    check("lat_c6_busy", 32'(gi[0].busy), 0);
    wait_done(0, s_done, 50, "single");
    check("single_reads", 32'(acc_cnt(0) - s_acc), 1);
    check("single_queue_empty", 32'(exp_q.size()), 0);

    // Slave stalls each read for 3 cycles.
    stall_set[0] = 3;
    s_done = done_cnt(0); s_acc = acc_cnt(0); s_rd = gi[0].rd_hi_total;
    push_run(0, 23'd256, 1);
    pulse_start(0);
    wait_done(0, s_done, 50, "stall");
    check("stall_read_cycles", 32'(gi[0].rd_hi_total - s_rd), 4);
    check("stall_reads", 32'(acc_cnt(0) - s_acc), 1);
    check("stall_addr", 32'(gi[0].acc_log[s_acc]), 256);
    check("stall_queue_empty", 32'(exp_q.size()), 0);
    stall_set[0] = 0;

    // Full 128-word run with random stalls and random ready; extra start mid-run.
    rdy_mode[1] = 2;
    stall_rnd[1] = 1;
    lat_set[1] = 2;
    s_done = done_cnt(1); s_acc = acc_cnt(1); s_hs = hs_cnt(1);
    push_run(1, 23'd0, 128);
    pulse_start(1);
    repeat (40) @(negedge clk);
    check("full_busy_mid", 32'(gi[1].busy), 1);
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    wait_done(1, s_done, 8000, "full");
    check("full_samples", 32'(hs_cnt(1) - s_hs), 256);
    check("full_reads", 32'(acc_cnt(1) - s_acc), 128);
    check("full_queue_empty", 32'(exp_q.size()), 0);

    // Address wrap at the top of the 23-bit space; start while busy ignored.
    stall_set[2] = 1;
    s_done = done_cnt(2); s_acc = acc_cnt(2); s_hs = hs_cnt(2);
    push_run(2, 23'h7FFFFF, 2);
    pulse_start(2);
    repeat (3) @(negedge clk);
    st[2] = 1'b1;
    @(negedge clk);
    st[2] = 1'b0;
    wait_done(2, s_done, 100, "wrap");
    check("wrap_reads", 32'(acc_cnt(2) - s_acc), 2);
    check("wrap_addr0", 32'(gi[2].acc_log[s_acc]), 32'h7FFFFF);
    check("wrap_addr1", 32'(gi[2].acc_log[s_acc + 1]), 0);
    check("wrap_samples", 32'(hs_cnt(2) - s_hs), 4);
    check("wrap_queue_empty", 32'(exp_q.size()), 0);

    // Reset while waiting for data; the late response must be ignored.
    lat_set[0] = 3;
    s_acc = acc_cnt(0); s_hs = hs_cnt(0); s_done = done_cnt(0);
    pulse_start(0);
    for (int n = 0; n < 20 && acc_cnt(0) == s_acc; n++) @(negedge clk);
    check("rstw_read_accepted", 32'(acc_cnt(0) - s_acc), 1);
    rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("rstw_valid", 32'(gi[0].valid), 0);
      check("rstw_read", 32'(gi[0].read), 0);
      check("rstw_busy", 32'(gi[0].busy), 0);
    end
    check("rstw_addr", 32'(gi[0].address), 0);
    check("rstw_data", 32'(gi[0].sdata), 0);
    check("rstw_idx", 32'(gi[0].sidx), 0);
    check("rstw_done", 32'(done_cnt(0) - s_done), 0);
    check("rstw_no_sample", 32'(hs_cnt(0) - s_hs), 0);

    lat_set[0] = 1;
    s_acc = acc_cnt(0); s_done = done_cnt(0);
    push_run(0, 23'd256, 1);
    pulse_start(0);
    wait_done(0, s_done, 50, "rerun");
    check("rerun_addr", 32'(gi[0].acc_log[s_acc]), 256);
    check("rerun_queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
